// File: rtl/lsu_align.sv
// Load/store alignment unit: maps byte/half/word requests onto word-aligned
// memory accesses with byte masks, splitting word-crossing accesses in two.
module lsu_align #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, SPLIT_HI = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  w_nmask, w_span;
  logic [63:0] w_wide, w_ld_cat;
  logic        w_acc, w_cross, w_err;

  logic        r_vld_p1, r_err_p1, r_split_p1;
  logic [29:0] r_word_p1;
  logic        r_we_p1, r_uns_p1;
  logic [1:0]  r_size_p1, r_off_p1;
  logic [3:0]  r_mask_hi_p1;
  logic [31:0] r_wdata_hi_p1, r_lo_buf_p1;

  function automatic logic [31:0] f_lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] v;
    case (sz)
      2'b00:   v = {{24{d[7] & ~uns}}, d[7:0]};
      2'b01:   v = {{16{d[15] & ~uns}}, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  always_comb begin
    case (req_size)
      2'b00:   w_nmask = 8'h01;
      2'b01:   w_nmask = 8'h03;
      default: w_nmask = 8'h0F;
    endcase
  end

  // Lanes 4..7 of the shifted span / data belong to the next word.
  assign w_span    = w_nmask << req_addr[1:0];
  assign w_cross   = |w_span[7:4];
  assign w_err     = (req_size == 2'b11) || (w_cross && !SPLIT_MISALIGNED);
  assign w_wide    = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
  assign req_ready = (r_state == IDLE) && !rst;
  assign w_acc     = req_valid && req_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_acc && !w_err && w_cross) w_state_nxt = SPLIT_HI;
      SPLIT_HI: w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = {req_addr[31:2], 2'b00};
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_mask  = 4'b0000;
    mem_wdata = 32'b0;
    if (!rst) begin
      if (r_state == SPLIT_HI) begin
        mem_addr = {r_word_p1 + 30'd1, 2'b00};
        mem_ren  = !r_we_p1;
        mem_wen  = r_we_p1;
        if (r_we_p1) begin
          mem_mask  = r_mask_hi_p1;
          mem_wdata = r_wdata_hi_p1;
        end
      end else if (w_acc && !w_err) begin
        mem_ren = !req_we;
        mem_wen = req_we;
        if (req_we) begin
          mem_mask  = w_span[3:0];
          mem_wdata = w_wide[31:0];
        end
      end
    end
  end

  // Stage p0 -> p1: control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_vld_p1   <= 1'b0;
      r_err_p1   <= 1'b0;
      r_split_p1 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vld_p1   <= (r_state == SPLIT_HI) || (w_acc && (w_err || !w_cross));
      r_err_p1   <= w_acc && w_err;
      r_split_p1 <= (r_state == SPLIT_HI);
    end
  end

  // Stage p0 -> p1: captured request and low-word buffer
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_word_p1     <= req_addr[31:2];
      r_we_p1       <= req_we;
      r_uns_p1      <= req_unsigned;
      r_size_p1     <= req_size;
      r_off_p1      <= req_addr[1:0];
      r_mask_hi_p1  <= w_span[7:4];
      r_wdata_hi_p1 <= w_wide[63:32] & f_lane_bits(w_span[7:4]);
    end
    if (r_state == SPLIT_HI) r_lo_buf_p1 <= mem_rdata;
  end

  assign w_ld_cat   = r_split_p1 ? {mem_rdata, r_lo_buf_p1} : {32'b0, mem_rdata};
  assign resp_valid = r_vld_p1;
  assign resp_err   = r_err_p1;
  assign resp_rdata = (r_vld_p1 && !r_err_p1 && !r_we_p1)
                    ? f_extend(w_ld_cat[{1'b0, r_off_p1, 3'b000} +: 32], r_size_p1, r_uns_p1)
                    : 32'b0;

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the execute/memory pipeline stage and the data port of the synchronous unified memory.
- Converts byte/halfword/word requests with arbitrary byte addresses into word-aligned memory accesses with byte masks.
- Shifts store data into byte lanes; extracts and sign/zero-extends load data one cycle after issue.
- Optionally splits misaligned accesses that cross a word boundary into two aligned accesses, using an internal FSM.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = split word-crossing accesses into two accesses; 0 = complete them as errors with no memory access.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; a request transfers when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse, for loads and stores.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; misaligned access with SPLIT_MISALIGNED=0, or size 11.
- mem_addr  out  32  word address to memory; bits [1:0] are always 00.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  32  lane-shifted write data.
- mem_mask  out  4  byte-lane write mask; bit i enables bits [8i+7:8i].
- mem_rdata  in  32  memory read data, valid the cycle after mem_ren.

Behaviour:
- Memory contract: the memory registers its address/enables on the clock edge. Read data appears one cycle after issue. A write is visible to a read issued in a later cycle.
- mem_* outputs are combinational from the accepted request (IDLE) or from the captured request (SPLIT_HI).
- Reset: state = IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0. While rst is high, mem_ren = mem_wen = 0 and req_ready = 0.
- Definitions: off = req_addr[1:0]; n = 1/2/4 bytes.
  - Crossing = off + n > 4.
  - Halfword at off = 1 is not crossing; halfword at off = 3 and word at off != 0 are crossing.
- FSM states: IDLE, SPLIT_HI. req_ready = (state == IDLE).
- IDLE, accepted non-crossing legal request (cycle T):
  - mem_addr = {addr[31:2], 00}.
  - Load: mem_ren = 1. Store: mem_wen = 1, mem_mask = ((1 << n) - 1) << off, mem_wdata = req_wdata << (8*off).
  - Capture we/size/unsigned/off.
  - T+1: resp_valid = 1; load data = (mem_rdata >> 8*off), truncated to n bytes, then extended.
  - Back-to-back acceptance allowed, one request per cycle.
- IDLE, accepted crossing request, SPLIT_MISALIGNED = 1 (cycle T):
  - Issue low access at {addr[31:2], 00}. Mask = lanes off..3. wdata = req_wdata << 8*off.
  - Capture the full request; go to SPLIT_HI.
- SPLIT_HI (T+1):
  - req_ready = 0.
  - Issue high access at ({addr[31:2], 00} + 4) mod 2^32, wrapping 0xFFFFFFFC -> 0x00000000.
  - Mask = lanes 0..(off + n - 5). wdata = req_wdata >> 8*(4 - off), unused lanes 0.
  - Load: latch mem_rdata into lo_buf. Return to IDLE.
- T+2: resp_valid = 1. Load data = ({mem_rdata, lo_buf} >> 8*off), truncated to n bytes, then extended. req_ready is 1 in this cycle.
- Error path (crossing with SPLIT_MISALIGNED = 0, or size 11):
  - No mem_ren/mem_wen.
  - Next cycle: resp_valid = 1, resp_err = 1, resp_rdata = 0.
- resp_valid is 0 in every cycle without a completion.
- resp_err = 0 on all successful completions.
- Reset asserted mid-split: the FSM returns to IDLE immediately. The pending response is dropped. A partially written store is not rolled back.
- No mem_ren and mem_wen together in any cycle.
- mem_mask = 0 whenever mem_wen = 0.

Test Plan:
- Load byte signed at 0x103, memory word 0x100 = 0x80FF0011 -> one ren at 0x100; T+1 resp_rdata = 0xFFFFFF80, resp_err = 0.
- Store half 0xBEEF at 0x102 -> mem_wen at 0x100, mask 1100, wdata 0xBEEF0000; a following load word at 0x100 over old 0x11223344 returns 0xBEEF3344.
- Load word at 0x101, memory 0x100 = 0x44332211, 0x104 = 0x88776655 -> ren at 0x100 (T), then 0x104 (T+1) with req_ready = 0; T+2 resp_rdata = 0x55443322.
- Store word 0xAABBCCDD at 0x0FFFFFFFF -> low access 0xFFFFFFFC, mask 1000, wdata 0xDD000000; high access 0x00000000, mask 0111, wdata 0x00AABBCC.
- With SPLIT_MISALIGNED = 0: load half at 0x203 -> no memory enable; next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0. Size 11 gives the same response.
- Assert rst during SPLIT_HI -> all outputs return to reset values asynchronously, and no resp_valid occurs. After release, an aligned load completes normally in 1 cycle.
